shift_sub_divider: RTL and testbench

SHIFT_SUB_DIVIDER -- requirements
Module: shift_sub_divider

---
 rtl/shift_sub_divider_pkg.sv | 14 +
 rtl/div_step.sv | 31 +++
 rtl/shift_sub_divider.sv | 159 +++++++++++++++
 tb/tb_shift_sub_divider.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_sub_divider_pkg.sv
// Shared definitions for the shift-subtract divider: FSM state encoding and default widths.
package shift_sub_divider_pkg;

    // Default dividend/quotient width and divisor/remainder width.
    localparam int unsigned DefaultDw = 8;
    localparam int unsigned DefaultVw = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract division step (combinational).
// Ports:
//   rem      - current partial remainder (VW+1 bits, always < divisor)
//   dbit     - next dividend bit, MSB first
//   m        - divisor
//   rem_next - partial remainder after the step
//   qbit     - quotient bit produced by the step
module div_step
    import shift_sub_divider_pkg::*;
#(
    parameter int unsigned VW = DefaultVw
) (
    input  logic [VW:0]   rem,
    input  logic          dbit,
    input  logic [VW-1:0] m,
    output logic [VW:0]   rem_next,
    output logic          qbit
);

    logic [VW+1:0] shifted;
    logic [VW+1:0] diff;

    always_comb begin
        shifted  = {rem, dbit};
        diff     = shifted - {2'b00, m};
        // rem < m keeps shifted below 2^(VW+1), so the top bit of diff is the borrow.
        qbit     = ~diff[VW+1];
        rem_next = qbit ? diff[VW:0] : shifted[VW:0];
    end

endmodule

// File: rtl/shift_sub_divider.sv
// Sequential restoring divider: q = p / m, r = p % m, one quotient bit per cycle.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   start     - begin a division (accepted only when idle)
//   p, m      - dividend (DW bits), divisor (VW bits)
//   busy      - division in progress (RUN or DONE)
//   done      - one-cycle pulse when results are valid
//   q, r      - quotient, remainder; held until the next result
//   div_zero  - divisor was zero
//   ovf       - quotient exceeds VW bits
// Build option: define DIV_OVERFLOW_CHK_EN to enable the ovf check; otherwise ovf is tied low.
module shift_sub_divider
    import shift_sub_divider_pkg::*;
#(
    parameter int unsigned DW = DefaultDw,
    parameter int unsigned VW = DefaultVw
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] p,
    input  logic [VW-1:0] m,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] q,
    output logic [VW-1:0] r,
    output logic          div_zero,
    output logic          ovf
);

    localparam int unsigned CntW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(DW - 1);

    state_e          state_q, state_d;
    logic [DW-1:0]   dvd_q, dvd_d;     // dividend shifts out MSB first, quotient shifts in at LSB
    logic [VW:0]     rem_q, rem_d;
    logic [VW-1:0]   m_q, m_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [DW-1:0]   q_q, q_d;
    logic [VW-1:0]   r_q, r_d;
    logic            dz_q, dz_d;

    logic [VW:0]     step_rem;
    logic            step_qbit;
    logic [DW-1:0]   quot_next;

    div_step #(
        .VW(VW)
    ) u_step (
        .rem      (rem_q),
        .dbit     (dvd_q[DW-1]),
        .m        (m_q),
        .rem_next (step_rem),
        .qbit     (step_qbit)
    );

    assign quot_next = {dvd_q[DW-2:0], step_qbit};

`ifdef DIV_OVERFLOW_CHK_EN
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;
`ifdef DIV_OVERFLOW_CHK_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    dvd_d = p;
                    m_d   = m;
                    rem_d = '0;
                    cnt_d = '0;
                    if (m == '0) begin
                        state_d = StDone;
                        q_d     = '1;
                        r_d     = '0;
                        dz_d    = 1'b1;
`ifdef DIV_OVERFLOW_CHK_EN
                        ovf_d   = 1'b0;
`endif
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                dvd_d = quot_next;
                rem_d = step_rem;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                    q_d     = quot_next;
                    r_d     = step_rem[VW-1:0];
                    dz_d    = 1'b0;
`ifdef DIV_OVERFLOW_CHK_EN
                    ovf_d   = (quot_next >> VW) != '0;
`endif
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            dvd_q   <= '0;
            rem_q   <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            rem_q   <= rem_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

`ifdef DIV_OVERFLOW_CHK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end
    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign q        = q_q;
    assign r        = r_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed bench for shift_sub_divider at default widths (DW=8, VW=4).
module tb_shift_sub_divider;

`ifdef DIV_OVERFLOW_CHK_EN
    localparam bit OvfChk = 1'b1;
`else
    localparam bit OvfChk = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] p_in;
    logic [3:0] m_in;
    logic       busy, done, div_zero, ovf;
    logic [7:0] q;
    logic [3:0] r;

    int tests = 0;
    int fails = 0;

    shift_sub_divider dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .p        (p_in),
        .m        (m_in),
        .busy     (busy),
        .done     (done),
        .q        (q),
        .r        (r),
        .div_zero (div_zero),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    // Pulses start for one cycle, then waits (bounded) for done; lat counts cycles after the
    // sampling edge, sampled on falling edges.
    task automatic run_div(input logic [7:0] pv, input logic [3:0] mv, output int lat);
        @(negedge clk);
        start = 1'b1;
        p_in  = pv;
        m_in  = mv;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b0;
        p_in  = '0;
        m_in  = '0;
        repeat (2) @(negedge clk);
        tests++;
        if ({busy, done, q, r, div_zero, ovf} !== 16'h0) begin
            fails++;
            $display("FAIL reset_outputs: got busy=%b done=%b q=%0d r=%0d dz=%b ovf=%b, want all 0",
                     busy, done, q, r, div_zero, ovf);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        int lat;
        run_div(8'd143, 4'd13, lat);
        tests++;
        if (lat !== 9) begin
            fails++;
            $display("FAIL basic_latency: got %0d want 9", lat);
        end
        tests++;
        if (q !== 8'd11 || r !== 4'd0 || div_zero !== 1'b0 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL basic_143_13: got q=%0d r=%0d dz=%b ovf=%b want q=11 r=0 dz=0 ovf=0",
                     q, r, div_zero, ovf);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || q !== 8'd11) begin
            fails++;
            $display("FAIL basic_pulse: got done=%b busy=%b q=%0d want done=0 busy=0 q=11",
                     done, busy, q);
        end
    endtask

    task automatic test_vectors;
        int lat;
        run_div(8'd100, 4'd7, lat);
        tests++;
        if (lat !== 9 || q !== 8'd14 || r !== 4'd2 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL vec_100_7: got lat=%0d q=%0d r=%0d ovf=%b want lat=9 q=14 r=2 ovf=0",
                     lat, q, r, ovf);
        end
        run_div(8'd225, 4'd15, lat);
        tests++;
        if (lat !== 9 || q !== 8'd15 || r !== 4'd0 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL vec_225_15: got lat=%0d q=%0d r=%0d ovf=%b want lat=9 q=15 r=0 ovf=0",
                     lat, q, r, ovf);
        end
    endtask

    task automatic test_div_zero;
        int lat;
        run_div(8'd200, 4'd0, lat);
        tests++;
        if (lat !== 1) begin
            fails++;
            $display("FAIL dz_latency: got %0d want 1", lat);
        end
        tests++;
        if (q !== 8'd255 || r !== 4'd0 || div_zero !== 1'b1 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL dz_result: got q=%0d r=%0d dz=%b ovf=%b want q=255 r=0 dz=1 ovf=0",
                     q, r, div_zero, ovf);
        end
        @(negedge clk);
        tests++;
        if (div_zero !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL dz_hold: got dz=%b busy=%b want dz=1 busy=0", div_zero, busy);
        end
    endtask

    task automatic test_overflow;
        int lat;
        run_div(8'd255, 4'd1, lat);
        tests++;
        if (lat !== 9 || q !== 8'd255 || r !== 4'd0 || div_zero !== 1'b0 || ovf !== OvfChk) begin
            fails++;
            $display("FAIL ovf_255_1: got lat=%0d q=%0d r=%0d dz=%b ovf=%b want lat=9 q=255 r=0 dz=0 ovf=%b",
                     lat, q, r, div_zero, ovf, OvfChk);
        end
    endtask

    task automatic test_ignore_start;
        int lat;
        @(negedge clk);
        start = 1'b1;
        p_in  = 8'd143;
        m_in  = 4'd13;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 40) begin
            if (lat == 3) begin
                start = 1'b1;
                p_in  = 8'd50;
                m_in  = 4'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        tests++;
        if (lat !== 9 || q !== 8'd11 || r !== 4'd0) begin
            fails++;
            $display("FAIL ignore_busy_start: got lat=%0d q=%0d r=%0d want lat=9 q=11 r=0",
                     lat, q, r);
        end
        // A start raised during the DONE cycle must not be accepted.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || q !== 8'd11) begin
            fails++;
            $display("FAIL ignore_done_start: got busy=%b done=%b q=%0d want busy=0 done=0 q=11",
                     busy, done, q);
        end
    endtask

    task automatic test_reset_abort;
        int  lat;
        bit  saw_done = 1'b0;
        @(negedge clk);
        start = 1'b1;
        p_in  = 8'd143;
        m_in  = 4'd13;
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            if (done) saw_done = 1'b1;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        if (done) saw_done = 1'b1;
        tests++;
        if (saw_done || {busy, done, q, r, div_zero, ovf} !== 16'h0) begin
            fails++;
            $display("FAIL reset_abort: got saw_done=%b busy=%b done=%b q=%0d r=%0d dz=%b ovf=%b want all 0",
                     saw_done, busy, done, q, r, div_zero, ovf);
        end
        rst = 1'b0;
        run_div(8'd100, 4'd7, lat);
        tests++;
        if (lat !== 9 || q !== 8'd14 || r !== 4'd2) begin
            fails++;
            $display("FAIL after_abort_100_7: got lat=%0d q=%0d r=%0d want lat=9 q=14 r=2",
                     lat, q, r);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_div_zero();
        test_overflow();
        test_ignore_start();
        test_reset_abort();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
